// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings for the hazard controller
// FSM states, forwarding select codes and the load result-source code.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// rtl/pipeline_hazard_ctrl_fwd_unit.sv - EX operand forwarding compare
// One instance per EX source operand; M-stage result wins over W-stage.
module pipeline_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_rs_addrE,
  input  logic       i_reg_wr_enM,
  input  logic [4:0] i_rd_addrM,
  input  logic       i_reg_wr_enW,
  input  logic [4:0] i_rd_addrW,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_reg_wr_enW && (i_rd_addrW != 5'd0) && (i_rd_addrW == i_rs_addrE))
      o_fwd = FWD_W;
    if (i_reg_wr_enM && (i_rd_addrM != 5'd0) && (i_rd_addrM == i_rs_addrE))
      o_fwd = FWD_M;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RV32I hazard/stall controller with dmem wait-state FSM
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [4:0]  i_rs1_addrD,
  input  logic [4:0]  i_rs2_addrD,
  input  logic [4:0]  i_rs1_addrE,
  input  logic [4:0]  i_rs2_addrE,
  input  logic [4:0]  i_rd_addrE,
  input  logic [1:0]  i_ctrl_result_srcE,
  input  logic        i_pc_srcE,
  input  logic        i_ctrl_reg_wr_enM,
  input  logic [4:0]  i_rd_addrM,
  input  logic        i_ctrl_reg_wr_enW,
  input  logic [4:0]  i_rd_addrW,
  input  logic        i_dmem_reqM,
  input  logic        i_dmem_ack,
  output logic        o_stallF,
  output logic        o_stallD,
  output logic        o_stallE,
  output logic        o_stallM,
  output logic        o_flushD,
  output logic        o_flushE,
  output logic        o_flushW,
  output logic [1:0]  o_fwd_aE,
  output logic [1:0]  o_fwd_bE,
  output logic        o_mem_err,
  output logic [1:0]  o_state,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_events
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      fwd_a, fwd_b;
  logic            lw_stall, mem_wait, mem_stall;

  pipeline_fwd_unit u_fwd_a (
    .i_rs_addrE   (i_rs1_addrE),
    .i_reg_wr_enM (i_ctrl_reg_wr_enM),
    .i_rd_addrM   (i_rd_addrM),
    .i_reg_wr_enW (i_ctrl_reg_wr_enW),
    .i_rd_addrW   (i_rd_addrW),
    .o_fwd        (fwd_a)
  );

  pipeline_fwd_unit u_fwd_b (
    .i_rs_addrE   (i_rs2_addrE),
    .i_reg_wr_enM (i_ctrl_reg_wr_enM),
    .i_rd_addrM   (i_rd_addrM),
    .i_reg_wr_enW (i_ctrl_reg_wr_enW),
    .i_rd_addrW   (i_rd_addrW),
    .o_fwd        (fwd_b)
  );

  assign lw_stall = (i_ctrl_result_srcE == RESULT_SRC_LOAD) && (i_rd_addrE != 5'd0) &&
                    ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));
  assign mem_wait  = i_dmem_reqM && !i_dmem_ack;
  assign mem_stall = mem_wait || (state_q == ST_ERR);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d = ST_WAIT;
          cnt_d   = TO_W'(1);
        end
      end
      ST_WAIT: begin
        // Request withdrawn without ack is treated like completion.
        if (!mem_wait) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == TO_LIMIT) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = ST_ERR;
    endcase
  end

  // Outputs forced quiet while reset is held, independent of the clock.
  always_comb begin
    o_stallF = 1'b0;
    o_stallD = 1'b0;
    o_stallE = 1'b0;
    o_stallM = 1'b0;
    o_flushD = 1'b0;
    o_flushE = 1'b0;
    o_flushW = 1'b0;
    if (i_rstn) begin
      if (mem_stall) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_stallE = 1'b1;
        o_stallM = 1'b1;
        o_flushW = 1'b1;
      end else if (i_pc_srcE) begin
        o_flushD = 1'b1;
        o_flushE = 1'b1;
      end else if (lw_stall) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_flushE = 1'b1;
      end
    end
  end

  assign o_fwd_aE  = i_rstn ? fwd_a : FWD_RF;
  assign o_fwd_bE  = i_rstn ? fwd_b : FWD_RF;
  assign o_mem_err = (state_q == ST_ERR);
  assign o_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_stallF || o_stallD || o_stallE || o_stallM) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (o_flushD || o_flushE) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cnt_q;
  assign o_flush_events = flush_cnt_q;
`else
  assign o_stall_cycles = '0;
  assign o_flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
// Instance uses MEM_TIMEOUT = 4; perf checks follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0]  result_srcE;
  logic        pc_srcE, wr_enM, wr_enW, reqM, ack;
  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [31:0] stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .i_clk (clk), .i_rstn (rstn),
    .i_rs1_addrD (rs1D), .i_rs2_addrD (rs2D),
    .i_rs1_addrE (rs1E), .i_rs2_addrE (rs2E), .i_rd_addrE (rdE),
    .i_ctrl_result_srcE (result_srcE), .i_pc_srcE (pc_srcE),
    .i_ctrl_reg_wr_enM (wr_enM), .i_rd_addrM (rdM),
    .i_ctrl_reg_wr_enW (wr_enW), .i_rd_addrW (rdW),
    .i_dmem_reqM (reqM), .i_dmem_ack (ack),
    .o_stallF (stallF), .o_stallD (stallD), .o_stallE (stallE), .o_stallM (stallM),
    .o_flushD (flushD), .o_flushE (flushE), .o_flushW (flushW),
    .o_fwd_aE (fwd_a), .o_fwd_bE (fwd_b),
    .o_mem_err (mem_err), .o_state (state),
    .o_stall_cycles (stall_cycles), .o_flush_events (flush_events)
  );

  // Packed view of the seven control outputs: {stallF,stallD,stallE,stallM,flushD,flushE,flushW}
  wire [6:0] ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    result_srcE = 2'b00; pc_srcE = 0; wr_enM = 0; wr_enW = 0; reqM = 0; ack = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    reqM = 1; pc_srcE = 1; wr_enM = 1; rdM = 5'd3; rs1E = 5'd3; rs2E = 5'd3;
    #2;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0); end
    total++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fwd_a, fwd_b); end
    tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", mem_err); end
    total++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cycles, flush_events); end
    clear_inputs();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    wr_enM = 1; rdM = 5'd5; wr_enW = 1; rdW = 5'd5; rs1E = 5'd5; rs2E = 5'd9;
    #1;
    total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_m_prio got=%b exp=10", fwd_a); end
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_b_nomatch got=%b exp=00", fwd_b); end
    rdM = 5'd0;
    #1;
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_w got=%b exp=01", fwd_a); end
    rdM = 5'd9;
    #1;
    total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL fwd_b_m got=%b exp=10", fwd_b); end
    wr_enM = 0;
    #1;
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_b_wren0 got=%b exp=00", fwd_b); end
    rdM = 0; rdW = 0; rs1E = 0; rs2E = 0; wr_enM = 1;
    #1;
    total++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b/%b exp=00/00", fwd_a, fwd_b); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    result_srcE = 2'b01; rdE = 5'd7; rs2D = 5'd7; rs1D = 5'd3;
    #1;
    total++; if (ctl !== 7'b1100010) begin bad++; $display("FAIL lw_stall got=%b exp=1100010", ctl); end
    tick();
    result_srcE = 2'b00; rdE = 5'd0;
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL lw_next got=%b exp=0000000", ctl); end
    result_srcE = 2'b01; rdE = 5'd0; rs1D = 5'd0;
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL lw_x0 got=%b exp=0000000", ctl); end
    result_srcE = 2'b00; rdE = 5'd3;
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL lw_notload got=%b exp=0000000", ctl); end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_over_lw();
    clear_inputs();
    result_srcE = 2'b01; rdE = 5'd7; rs1D = 5'd7; pc_srcE = 1;
    #1;
    total++; if (ctl !== 7'b0000110) begin bad++; $display("FAIL branch_lw got=%b exp=0000110", ctl); end
    clear_inputs();
    tick();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    reqM = 1; ack = 0; pc_srcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== 7'b1111001) begin bad++; $display("FAIL memwait_ctl[%0d] got=%b exp=1111001", i, ctl); end
      total++; if (state !== ((i == 0) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL memwait_state[%0d] got=%0d exp=%0d", i, state, (i == 0) ? 0 : 1); end
      tick();
    end
    ack = 1;
    #1;
    total++; if (ctl !== 7'b0000110) begin bad++; $display("FAIL memwait_ack_branch got=%b exp=0000110", ctl); end
    tick();
    clear_inputs();
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL memwait_back_run got=%0d exp=0", state); end
    reqM = 1; ack = 1;
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL single_ack_ctl got=%b exp=0000000", ctl); end
    tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL single_ack_state got=%0d exp=0", state); end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    clear_inputs();
    reqM = 1;
    for (int i = 0; i < 4; i++) tick();
    total++; if (state !== 2'd1 || mem_err !== 1'b0) begin bad++; $display("FAIL timeout_edge got=%0d/%b exp=1/0", state, mem_err); end
    tick();
    total++; if (state !== 2'd2 || mem_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%0d/%b exp=2/1", state, mem_err); end
    ack = 1;
    #1;
    total++; if (ctl !== 7'b1111001) begin bad++; $display("FAIL err_late_ack got=%b exp=1111001", ctl); end
    tick();
    reqM = 0; ack = 0; pc_srcE = 1;
    #1;
    total++; if (state !== 2'd2 || ctl !== 7'b1111001) begin bad++; $display("FAIL err_sticky got=%0d/%b exp=2/1111001", state, ctl); end
    #2;
    rstn = 1'b0;
    #1;
    total++; if (state !== 2'd0 || mem_err !== 1'b0) begin bad++; $display("FAIL err_async_rst got=%0d/%b exp=0/0", state, mem_err); end
    clear_inputs();
    tick();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_perf();
    logic [31:0] exp_s, exp_f;
    do_reset();
    clear_inputs();
    reqM = 1;
    for (int i = 0; i < 3; i++) tick();
    ack = 1;
    tick();
    clear_inputs();
    result_srcE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
    tick();
    clear_inputs();
    pc_srcE = 1;
    tick();
    clear_inputs();
    tick();
`ifdef HAZARD_PERF_CNT_EN
    exp_s = 32'd4; exp_f = 32'd2;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    total++; if (stall_cycles !== exp_s) begin bad++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cycles, exp_s); end
    total++; if (flush_events !== exp_f) begin bad++; $display("FAIL perf_flush got=%0d exp=%0d", flush_events, exp_f); end
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_lw();
    test_mem_wait();
    test_timeout();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
